bus_cycle_arbiter: RTL and testbench
====================================

Name: bus_cycle_arbiter

Overview:
- Shares the 8-bit, 20-bit-address memory/IO bus between two requesters, e.g. the CPU core and a DMA engine.
- Runs one 8086-style bus cycle (T1/T2/T3/Tw/T4) per grant.
- Drives ALE, RD, WR, DEN, IOM, Address and write data toward the memory model, and returns read data plus a one-cycle ack to the granted requester.
- Round-robin arbitration; wait states come from a fixed minimum count plus the READY input.

Parameters:
- ADDR_W, 20, address width
- DATA_W, 8, data width
- WAIT_STATES, 0, minimum Tw cycles inserted after T3 (0..15)

Ports:
- CLK  in  1  single system clock, all state on posedge
- RESET  in  1  asynchronous, active-low reset
- req0 / req1  in  1  bus request, held until matching ack
- we0 / we1  in  1  1 = write, 0 = read
- iom0 / iom1  in  1  0 = memory cycle, 1 = IO cycle
- addr0 / addr1  in  ADDR_W  cycle address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data, valid while ack is high and held until the next read completes
- ALE  out  1  address latch enable
- RD  out  1  active-low read strobe
- WR  out  1  active-low write strobe
- DEN  out  1  data enable, write cycles only
- IOM  out  1  memory/IO select
- Address  out  ADDR_W  bus address
- Dout  out  DATA_W  write data to bus
- Din  in  DATA_W  read data from bus
- READY  in  1  bus ready; low extends the cycle

Behaviour:
- Reset (RESET=0, asynchronous):
  - State=IDLE, ALE=0, RD=1, WR=1, DEN=0, IOM=1, Address=0, Dout=0, rdata=0, ack0=ack1=0.
  - last_grant=1, so requester 0 wins the first tie.
  - A reset mid-cycle abandons the cycle: no ack is issued and the strobes return to inactive immediately.
- States: IDLE, T1, T2, T3, TW, T4. All outputs are registered.
- IDLE:
  - If req0 or req1 is high, grant to the requester with a request. If both request, grant the one that is not last_grant.
  - On the transition to T1: latch that requester's we/iom/addr/wdata into Address/IOM/Dout and internal we_r; update last_grant.
  - No request: stay in IDLE, outputs inactive.
- T1:
  - ALE=1, Address and IOM valid. Next state is T2.
- T2:
  - ALE=0.
  - Read: RD=0.
  - Write: WR=0, DEN=1.
  - Next state is T3.
- T3:
  - Strobes held.
  - If WAIT_STATES>0 or READY=0, go to TW and load wait_cnt=WAIT_STATES. Otherwise go to T4.
- TW:
  - Strobes held.
  - wait_cnt decrements toward 0.
  - Leave for T4 only when wait_cnt has reached 0 and READY=1 (both sampled at the same edge). Otherwise stay.
- T4:
  - RD=1, WR=1, DEN=0.
  - On the T3/TW->T4 edge of a read, Din is captured into rdata.
  - The granted requester's ack is 1 for exactly this cycle.
  - Next state is IDLE (one mandatory idle cycle between bus cycles).
- Latency and strobe widths:
  - Minimum cycle with WAIT_STATES=0 and READY=1: request seen in IDLE at cycle N, then T1 at N+1, T2 at N+2, T3 at N+3, ack at N+4.
  - RD/WR are low for 2 + (number of TW cycles) cycles.
- Requester rules:
  - A requester keeps req and its operands stable until it sees ack, then drops req at that edge.
  - Dropping req after the grant is ignored: the cycle completes and ack is still pulsed.
  - Inputs of the non-granted requester are ignored for the whole cycle.
- Simultaneous events:
  - Both requesters held high continuously are served strictly alternately: 0, 1, 0, 1 …
  - READY is ignored outside T3/TW.

Decomposition:
- Package bus_pkg:
  - bus_state_t enum: IDLE, T1, T2, T3, TW, T4, one-hot 6-bit encoding.
  - ADDR_W/DATA_W default constants.
  - Bus-cycle type enum {BUS_READ, BUS_WRITE}.
- One sub-module, rr_arbiter2:
  - Combinational 2-way round-robin grant from req[1:0] and last_grant.
  - The last_grant register itself stays in the top.

Test Plan:
- Read, basic timing: WAIT_STATES=0, req0=1, we0=0, iom0=0, addr0=20'h00010, Din=8'hA5 -> ALE high exactly 1 cycle, RD low 2 cycles, ack0 four cycles after the request is seen, rdata=8'hA5, ack1 never asserted.
- Write with wait state: WAIT_STATES=1, req1=1, we1=1, addr1=20'hFFFFF, wdata1=8'h3C -> WR low 3 cycles, DEN high concurrently, Dout=8'h3C, Address=20'hFFFFF, one ack1 pulse.
- Contention: req0 and req1 held high with distinct addresses for 4 grants -> grant order 0,1,0,1, one IDLE cycle between cycles, each ack one cycle wide.
- READY stretch: READY=0 during T3 for 3 cycles, WAIT_STATES=0 -> 3 TW cycles, RD low 5 cycles, rdata captured from Din on the edge READY=1 is seen.
- Reset mid-cycle: RESET=0 asserted during TW -> RD/WR=1, ALE=0, DEN=0, IOM=1 immediately without a clock edge, no ack. After release with req0 held, a fresh cycle starts with requester 0.
- IO select: iom1=1 read -> IOM=1 throughout T1–T4. A following iom0=0 read -> IOM=0 from T1.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_pkg
// Brief   : Shared types and default widths for the bus cycle arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package bus_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    T1   = 6'b000010,
    T2   = 6'b000100,
    T3   = 6'b001000,
    TW   = 6'b010000,
    T4   = 6'b100000
  } bus_state_t;

  typedef enum logic {
    BUS_READ  = 1'b0,
    BUS_WRITE = 1'b1
  } bus_op_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter2
// Brief   : Combinational two-way round-robin grant; a tie goes to the
//           requester that did not win last time.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = (req_i == 2'b11) ? ~last_grant_i : req_i[1];
  end

endmodule
`default_nettype wire

// File: rtl/bus_cycle_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bus_cycle_arbiter
// Brief   : Shares an 8086-style T1/T2/T3/Tw/T4 bus between two requesters
//           with round-robin arbitration and READY/fixed wait states.
// Revision: 1.0 - initial release
// ============================================================================
module bus_cycle_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              iom0,
  input  logic              iom1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              ALE,
  output logic              RD,
  output logic              WR,
  output logic              DEN,
  output logic              IOM,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Dout,
  input  logic [DATA_W-1:0] Din,
  input  logic              READY
);

  localparam logic [3:0] C_WAIT = 4'(WAIT_STATES);

  bus_state_t        state_q;
  bus_op_t           op_q;
  logic              owner_q;
  logic              last_grant_q;
  logic [3:0]        wait_cnt_q;
  logic [3:0]        wait_cnt_d;
  logic              finish_d;
  logic              gnt_valid;
  logic              gnt_idx;
  logic              ale_q;
  logic              rd_n_q;
  logic              wr_n_q;
  logic              den_q;
  logic              iom_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ack0_q;
  logic              ack1_q;

  rr_arbiter2 u_arb (
    .req_i        ({req1, req0}),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_idx_o    (gnt_idx)
  );

  // The counter is judged on its post-decrement value, so WAIT_STATES=N
  // yields exactly N Tw cycles when READY stays high.
  always_comb begin
    wait_cnt_d = (wait_cnt_q == 4'd0) ? 4'd0 : wait_cnt_q - 4'd1;
    finish_d   = READY && (((state_q == T3) && (C_WAIT == 4'd0)) ||
                           ((state_q == TW) && (wait_cnt_d == 4'd0)));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      op_q         <= BUS_READ;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= 4'd0;
      ale_q        <= 1'b0;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      den_q        <= 1'b0;
      iom_q        <= 1'b1;
      addr_q       <= '0;
      dout_q       <= '0;
      rdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            state_q      <= T1;
            ale_q        <= 1'b1;
            owner_q      <= gnt_idx;
            last_grant_q <= gnt_idx;
            if (gnt_idx) begin
              op_q   <= we1 ? BUS_WRITE : BUS_READ;
              iom_q  <= iom1;
              addr_q <= addr1;
              dout_q <= wdata1;
            end else begin
              op_q   <= we0 ? BUS_WRITE : BUS_READ;
              iom_q  <= iom0;
              addr_q <= addr0;
              dout_q <= wdata0;
            end
          end
        end
        T1: begin
          ale_q   <= 1'b0;
          state_q <= T2;
          if (op_q == BUS_WRITE) begin
            wr_n_q <= 1'b0;
            den_q  <= 1'b1;
          end else begin
            rd_n_q <= 1'b0;
          end
        end
        T2: state_q <= T3;
        T3: begin
          if (!finish_d) begin
            state_q    <= TW;
            wait_cnt_q <= C_WAIT;
          end
        end
        TW:      wait_cnt_q <= wait_cnt_d;
        T4:      state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // Completion overrides the case above: release strobes and pulse ack.
      if (finish_d) begin
        state_q <= T4;
        rd_n_q  <= 1'b1;
        wr_n_q  <= 1'b1;
        den_q   <= 1'b0;
        ack0_q  <= ~owner_q;
        ack1_q  <= owner_q;
        if (op_q == BUS_READ) rdata_q <= Din;
      end
    end
  end

  assign ALE     = ale_q;
  assign RD      = rd_n_q;
  assign WR      = wr_n_q;
  assign DEN     = den_q;
  assign IOM     = iom_q;
  assign Address = addr_q;
  assign Dout    = dout_q;
  assign rdata   = rdata_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_cycle_arbiter
// Brief   : Scoreboard bench for bus_cycle_arbiter (WAIT_STATES 0 and 1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_cycle_arbiter;

  localparam int AW = 20;
  localparam int DW = 8;

  logic          CLK   = 1'b0;
  logic          RESET = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic          iom0 = 1'b0, iom1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, Din = '0;
  logic          READY = 1'b1;
  logic          sel   = 1'b0;

  logic          req0_a, req1_a, req0_b, req1_b;
  logic          ack0_a, ack1_a, ale_a, rd_a, wr_a, den_a, iom_a;
  logic          ack0_b, ack1_b, ale_b, rd_b, wr_b, den_b, iom_b;
  logic [DW-1:0] rdata_a, dout_a, rdata_b, dout_b;
  logic [AW-1:0] addr_a, addr_b;

  logic          m_ack0, m_ack1, m_ale, m_rd, m_wr, m_den, m_iom;
  logic [DW-1:0] m_rdata, m_dout;
  logic [AW-1:0] m_addr;

  assign req0_a = req0 & ~sel;
  assign req1_a = req1 & ~sel;
  assign req0_b = req0 & sel;
  assign req1_b = req1 & sel;

  assign m_ack0  = sel ? ack0_b  : ack0_a;
  assign m_ack1  = sel ? ack1_b  : ack1_a;
  assign m_ale   = sel ? ale_b   : ale_a;
  assign m_rd    = sel ? rd_b    : rd_a;
  assign m_wr    = sel ? wr_b    : wr_a;
  assign m_den   = sel ? den_b   : den_a;
  assign m_iom   = sel ? iom_b   : iom_a;
  assign m_rdata = sel ? rdata_b : rdata_a;
  assign m_dout  = sel ? dout_b  : dout_a;
  assign m_addr  = sel ? addr_b  : addr_a;

  bus_cycle_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .req0(req0_a), .req1(req1_a), .we0(we0), .we1(we1),
    .iom0(iom0), .iom1(iom1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0),
    .wdata1(wdata1), .ack0(ack0_a), .ack1(ack1_a), .rdata(rdata_a), .ALE(ale_a),
    .RD(rd_a), .WR(wr_a), .DEN(den_a), .IOM(iom_a), .Address(addr_a),
    .Dout(dout_a), .Din(Din), .READY(READY)
  );

  bus_cycle_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .req0(req0_b), .req1(req1_b), .we0(we0), .we1(we1),
    .iom0(iom0), .iom1(iom1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0),
    .wdata1(wdata1), .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b), .ALE(ale_b),
    .RD(rd_b), .WR(wr_b), .DEN(den_b), .IOM(iom_b), .Address(addr_b),
    .Dout(dout_b), .Din(Din), .READY(READY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          gnt;
    logic          we;
    logic          iom;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            tw;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic g, input logic we, input logic iom,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input int tw);
    exp_t e;
    e.gnt = g; e.we = we; e.iom = iom; e.addr = a; e.data = d; e.tw = tw;
    sb_q.push_back(e);
  endtask

  // Requester model: holds req/operands until it sees its ack, optionally
  // pulling READY low from T3 onwards for ready_low cycles.
  task automatic run_req(input logic idx, input logic we, input logic iom,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int ready_low, input logic [DW-1:0] dv);
    int k;
    bit done;
    if (idx) begin
      we1 = we; iom1 = iom; addr1 = a; wdata1 = wd; req1 = 1'b1;
    end else begin
      we0 = we; iom0 = iom; addr0 = a; wdata0 = wd; req0 = 1'b1;
    end
    Din  = (ready_low > 0) ? 8'h11 : dv;
    k    = 0;
    done = 1'b0;
    while (!done && k < 40) begin
      @(posedge CLK);
      #1;
      k++;
      if (ready_low > 0 && k == 3) READY = 1'b0;
      if (ready_low > 0 && k == 3 + ready_low) begin
        READY = 1'b1;
        Din   = dv;
      end
      if ((idx ? m_ack1 : m_ack0) === 1'b1) begin
        done = 1'b1;
        if (idx) req1 = 1'b0;
        else     req0 = 1'b0;
      end
    end
    check(idx ? "ack1_seen" : "ack0_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic gap();
    repeat (2) @(posedge CLK);
    #1;
  endtask

  // Monitor: measures each bus cycle from ALE to ack and compares it with
  // the oldest scoreboard entry.
  bit            in_cyc = 1'b0, ack_prev = 1'b0, den_bad = 1'b0, iom_chg = 1'b0;
  int            cyc = 0, ale_n = 0, rd_n = 0, wr_n = 0, den_n = 0, lo;
  logic          iom_cap = 1'b0;
  logic [AW-1:0] addr_cap = '0;
  logic [DW-1:0] dout_cap = '0;
  logic [DW-1:0] last_rd [2];
  exp_t          e_m;

  always @(negedge CLK) begin
    if (!RESET) begin
      in_cyc     = 1'b0;
      ack_prev   = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
    end else begin
      if (ack_prev) check("idle_after_ack", {29'd0, m_ale, m_ack0, m_ack1}, 32'd0);
      ack_prev = 1'b0;
      if (m_ale && !in_cyc) begin
        in_cyc = 1'b1; cyc = 0; ale_n = 0; rd_n = 0; wr_n = 0; den_n = 0;
        den_bad = 1'b0; iom_chg = 1'b0; iom_cap = m_iom; addr_cap = m_addr;
        dout_cap = '0;
      end
      if (in_cyc) begin
        cyc++;
        if (m_ale) ale_n++;
        if (!m_rd) rd_n++;
        if (!m_wr) begin
          wr_n++;
          dout_cap = m_dout;
        end
        if (m_den) den_n++;
        if (m_den === m_wr) den_bad = 1'b1;
        if (m_iom !== iom_cap) iom_chg = 1'b1;
      end
      if (m_ack0 || m_ack1) begin
        ack_prev = 1'b1;
        if (!in_cyc || sb_q.size() == 0) begin
          check("unexpected_ack", {30'd0, m_ack1, m_ack0}, 32'd0);
        end else begin
          e_m = sb_q.pop_front();
          lo  = 2 + e_m.tw;
          check("grant", {30'd0, m_ack1, m_ack0}, e_m.gnt ? 32'd2 : 32'd1);
          check("address", {12'd0, addr_cap}, {12'd0, e_m.addr});
          check("iom", {31'd0, iom_cap}, {31'd0, e_m.iom});
          check("iom_stable", {31'd0, iom_chg}, 32'd0);
          check("ale_cycles", ale_n, 32'd1);
          check("cycle_len", cyc, 4 + e_m.tw);
          check("rd_low", rd_n, e_m.we ? 32'd0 : lo);
          check("wr_low", wr_n, e_m.we ? lo : 32'd0);
          check("den_vs_wr", {31'd0, den_bad}, 32'd0);
          if (e_m.we) begin
            check("den_high", den_n, lo);
            check("dout", {24'd0, dout_cap}, {24'd0, e_m.data});
            check("rdata_held", {24'd0, m_rdata}, {24'd0, last_rd[sel]});
          end else begin
            check("rdata", {24'd0, m_rdata}, {24'd0, e_m.data});
            last_rd[sel] = e_m.data;
          end
          in_cyc = 1'b0;
        end
      end
    end
  end

  initial begin
    #1 RESET = 1'b0;
    #1;
    check("reset_ctl", {25'd0, m_ale, m_rd, m_wr, m_den, m_iom, m_ack0, m_ack1}, 32'b0110100);
    check("reset_addr", {12'd0, m_addr}, 32'd0);
    check("reset_data", {16'd0, m_dout, m_rdata}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Basic read, requester 0
    push(1'b0, 1'b0, 1'b0, 20'h00010, 8'hA5, 0);
    run_req(1'b0, 1'b0, 1'b0, 20'h00010, 8'h00, 0, 8'hA5);
    gap();

    // IO select: IO read from 1, then memory read from 0
    push(1'b1, 1'b0, 1'b1, 20'h003F8, 8'hC3, 0);
    run_req(1'b1, 1'b0, 1'b1, 20'h003F8, 8'h00, 0, 8'hC3);
    gap();
    push(1'b0, 1'b0, 1'b0, 20'h12345, 8'h96, 0);
    run_req(1'b0, 1'b0, 1'b0, 20'h12345, 8'h00, 0, 8'h96);
    gap();

    // READY held low for 3 cycles from T3
    push(1'b1, 1'b0, 1'b0, 20'h0BEEF, 8'h5A, 3);
    run_req(1'b1, 1'b0, 1'b0, 20'h0BEEF, 8'h00, 3, 8'h5A);
    gap();

    // Contention: strict alternation 0,1,0,1
    push(1'b0, 1'b0, 1'b0, 20'h01000, 8'h77, 0);
    push(1'b1, 1'b1, 1'b0, 20'h02000, 8'hE1, 0);
    push(1'b0, 1'b0, 1'b0, 20'h01001, 8'h77, 0);
    push(1'b1, 1'b1, 1'b0, 20'h02001, 8'h1E, 0);
    fork
      begin
        run_req(1'b0, 1'b0, 1'b0, 20'h01000, 8'h00, 0, 8'h77);
        @(posedge CLK); #1;
        run_req(1'b0, 1'b0, 1'b0, 20'h01001, 8'h00, 0, 8'h77);
      end
      begin
        run_req(1'b1, 1'b1, 1'b0, 20'h02000, 8'hE1, 0, 8'h77);
        @(posedge CLK); #1;
        run_req(1'b1, 1'b1, 1'b0, 20'h02001, 8'h1E, 0, 8'h77);
      end
    join
    gap();

    // Reset during TW abandons the cycle
    we0 = 1'b0; iom0 = 1'b0; addr0 = 20'h0ABCD; Din = 8'h42; req0 = 1'b1;
    repeat (3) @(posedge CLK);
    #1 READY = 1'b0;
    @(posedge CLK);
    #2;
    check("rd_low_in_tw", {31'd0, m_rd}, 32'd0);
    RESET = 1'b0;
    #1;
    check("abort_ctl", {25'd0, m_ale, m_rd, m_wr, m_den, m_iom, m_ack0, m_ack1}, 32'b0110100);
    check("abort_addr", {12'd0, m_addr}, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    check("held_in_reset", {25'd0, m_ale, m_rd, m_wr, m_den, m_iom, m_ack0, m_ack1}, 32'b0110100);
    READY = 1'b1;
    push(1'b0, 1'b0, 1'b0, 20'h0ABCD, 8'h42, 0);
    RESET = 1'b1;
    run_req(1'b0, 1'b0, 1'b0, 20'h0ABCD, 8'h00, 0, 8'h42);
    gap();

    // Write with one fixed wait state on the WAIT_STATES=1 instance
    sel = 1'b1;
    push(1'b1, 1'b1, 1'b0, 20'hFFFFF, 8'h3C, 1);
    run_req(1'b1, 1'b1, 1'b0, 20'hFFFFF, 8'h3C, 0, 8'h00);
    gap();

    repeat (3) @(posedge CLK);
    #1;
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
